// File: rtl/tick_pkg.sv
// tick_pkg: definitions shared by the tick generator, its prescaler and its
// interface.
//   state_t     - controller states (IDLE, RUN, STEP)
//   DEF_WIDTH   - default prescaler/divider width
//   DEF_CNT_W   - default width of the wrapping tick tally
package tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 2;

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: command and status bundle of the tick generator.
//   start/stop/step - level commands, sampled on every rising clk edge
//   div             - tick period minus 1, latched on entry to RUN/STEP
//   tick            - registered one-cycle enable pulse
//   running         - high while in RUN or STEP
//   phase           - current prescaler value
//   ticks           - wrapping count of ticks issued
//   state           - controller state, exposed for debug
// There is no valid/ready handshake: commands are plain levels. Every edge
// acts on whatever is present, with priority stop > start > step.
// All outputs are registered.
interface tick_gen_if
  import tick_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             stop;
  logic             step;
  logic [WIDTH-1:0] div;
  logic             tick;
  logic             running;
  logic [WIDTH-1:0] phase;
  logic [CNT_W-1:0] ticks;
  state_t           state;

  modport master (
    output start, stop, step, div,
    input  tick, running, phase, ticks, state
  );

  modport slave (
    input  start, stop, step, div,
    output tick, running, phase, ticks, state
  );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..div_q and then wraps.
//   clk, rst  - clock and synchronous active-high reset
//   clear     - force the count to 0 (takes priority over enable)
//   enable    - advance the count this edge
//   div_q     - terminal value
//   count     - current prescaler value
//   terminal  - count == div_q; the count wraps to 0 on an enabled edge
module tick_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] cnt_q;

  assign terminal = (cnt_q == div_q);
  assign count    = cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= terminal ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: programmable tick generator with continuous (RUN) and single-shot
// (STEP) modes.
//   clk    - single clock; all state updates on the rising edge
//   reset  - synchronous, active-high; overrides all commands
//   bus    - tick_gen_if slave: start/stop/step/div in,
//            tick/running/phase/ticks/state out
// The period is div_q+1 cycles. div is captured only when entering RUN or STEP
// from IDLE. A STEP that receives start becomes RUN and keeps its phase.
module tick_gen
  import tick_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  tick_gen_if.slave  bus
);

  state_t           state, state_n;
  logic [WIDTH-1:0] div_q;
  logic             tick_q;
  logic             running_q;
  logic [CNT_W-1:0] ticks_q;

  logic             presc_clear;
  logic             presc_en;
  logic             load_div;
  logic             tick_d;
  logic             terminal;
  logic [WIDTH-1:0] phase;

  tick_prescaler #(.WIDTH(WIDTH)) u_presc (
    .clk      (clk),
    .rst      (reset),
    .clear    (presc_clear),
    .enable   (presc_en),
    .div_q    (div_q),
    .count    (phase),
    .terminal (terminal)
  );

  always_comb begin
    state_n     = state;
    presc_clear = 1'b0;
    presc_en    = 1'b0;
    load_div    = 1'b0;
    tick_d      = 1'b0;
    case (state)
      ST_IDLE: begin
        presc_clear = 1'b1;
        if (!bus.stop) begin
          if (bus.start) begin
            state_n  = ST_RUN;
            load_div = 1'b1;
          end else if (bus.step) begin
            state_n  = ST_STEP;
            load_div = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // stop also suppresses a tick that would land on this edge
        if (bus.stop) begin
          state_n     = ST_IDLE;
          presc_clear = 1'b1;
        end else begin
          presc_en = 1'b1;
          tick_d   = terminal;
        end
      end
      ST_STEP: begin
        if (bus.stop) begin
          state_n     = ST_IDLE;
          presc_clear = 1'b1;
        end else begin
          presc_en = 1'b1;
          tick_d   = terminal;
          // start converts to RUN without a reload; otherwise the single
          // tick ends the step on the same edge
          if (bus.start) begin
            state_n = ST_RUN;
          end else if (terminal) begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n     = ST_IDLE;
        presc_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      ticks_q   <= '0;
    end else begin
      state     <= state_n;
      if (load_div) begin
        div_q <= bus.div;
      end
      tick_q    <= tick_d;
      running_q <= (state_n != ST_IDLE);
      if (tick_d) begin
        ticks_q <= ticks_q + CNT_W'(1);
      end
    end
  end

  assign bus.tick    = tick_q;
  assign bus.running = running_q;
  assign bus.phase   = phase;
  assign bus.ticks   = ticks_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;
  import tick_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int VW    = 2 + WIDTH + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tick_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tick_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [VW-1:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_in(input bit s, input bit p, input bit st, input int d);
    bus.start = s;
    bus.stop  = p;
    bus.step  = st;
    bus.div   = WIDTH'(d);
  endtask

  // one rising edge; outputs are sampled 1ns after it
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    clk_step();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int               m_state;  // 0 idle, 1 run, 2 step
  logic [WIDTH-1:0] m_presc, m_divq;
  logic             m_tick, m_run;
  logic [CNT_W-1:0] m_ticks;

  task model_edge();
    logic term;
    m_tick = 1'b0;
    if (reset) begin
      m_state = 0; m_presc = '0; m_divq = '0; m_ticks = '0;
    end else if (m_state == 0) begin
      m_presc = '0;
      if (bus.stop) begin
        m_state = 0;
      end else if (bus.start) begin
        m_state = 1; m_divq = bus.div;
      end else if (bus.step) begin
        m_state = 2; m_divq = bus.div;
      end
    end else if (bus.stop) begin
      m_state = 0; m_presc = '0;
    end else begin
      term = (m_presc == m_divq);
      m_tick  = term;
      m_presc = term ? '0 : m_presc + 1'b1;
      if (term) m_ticks = m_ticks + 1'b1;
      if (m_state == 2) begin
        if (bus.start) m_state = 1;
        else if (term) m_state = 0;
      end
    end
    m_run = (m_state != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] e;
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    clk_step();
    clk_step();
    reset = 1'b0;
    check("rst_tick",    bus.tick, 0);
    check("rst_running", bus.running, 0);
    check("rst_phase",   bus.phase, 0);
    check("rst_ticks",   bus.ticks, 0);
    check("rst_state",   bus.state, ST_IDLE);

    // div=3 start pulse: ticks every 4 cycles, tally 1,2,3,0,1
    do_reset();
    set_in(1, 0, 0, 3);
    clk_step();
    set_in(0, 0, 0, 3);
    for (int k = 1; k <= 20; k++) begin
      clk_step();
      check("run3_tick", bus.tick, (k % 4 == 0));
      if (k % 4 == 0) check("run3_ticks", bus.ticks, (k / 4) % 4);
    end

    // div=0 start held: tick every cycle from the second, tally wraps
    do_reset();
    set_in(1, 0, 0, 0);
    clk_step();
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      check("div0_tick",  bus.tick, 1);
      check("div0_ticks", bus.ticks, k % 4);
    end

    // div=2 step pulse: single tick 3 cycles later, running drops with it
    do_reset();
    set_in(0, 0, 1, 2);
    clk_step();
    set_in(0, 0, 0, 2);
    check("step_run0", bus.running, 1);
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      check("step_tick", bus.tick, (k == 3));
      check("step_running", bus.running, (k < 3));
      if (k >= 3) check("step_state", bus.state, ST_IDLE);
    end
    check("step_ticks", bus.ticks, 1);

    // div=5: stop on the edge where phase == 5 suppresses the tick
    do_reset();
    set_in(1, 0, 0, 5);
    clk_step();
    set_in(0, 0, 0, 5);
    for (int k = 1; k <= 5; k++) clk_step();
    check("stop_phase5", bus.phase, 5);
    set_in(0, 1, 0, 5);
    clk_step();
    set_in(0, 0, 0, 5);
    check("stop_tick",    bus.tick, 0);
    check("stop_running", bus.running, 0);
    check("stop_phase",   bus.phase, 0);
    check("stop_ticks",   bus.ticks, 0);
    clk_step();
    check("stop_tick2",   bus.tick, 0);

    // div=4, div changed to 1 mid-run: period stays 5
    do_reset();
    set_in(1, 0, 0, 4);
    clk_step();
    set_in(0, 0, 0, 4);
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) set_in(0, 0, 0, 1);
      clk_step();
      check("latch_tick", bus.tick, (k % 5 == 0));
    end
    set_in(0, 1, 0, 1);
    clk_step();
    check("latch_stop_run", bus.running, 0);
    // all three commands together from IDLE: stop wins
    set_in(1, 1, 1, 1);
    clk_step();
    check("all3_running", bus.running, 0);
    check("all3_state",   bus.state, ST_IDLE);
    check("all3_phase",   bus.phase, 0);
    clk_step();
    check("all3_state2",  bus.state, ST_IDLE);
    set_in(0, 0, 0, 1);

    // reset with phase == div mid-run: no tick afterwards
    do_reset();
    set_in(1, 0, 0, 3);
    clk_step();
    set_in(0, 0, 0, 3);
    for (int k = 1; k <= 3; k++) clk_step();
    check("rrun_phase3", bus.phase, 3);
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    check("rrun_tick",    bus.tick, 0);
    check("rrun_running", bus.running, 0);
    check("rrun_phase",   bus.phase, 0);
    check("rrun_ticks",   bus.ticks, 0);
    check("rrun_state",   bus.state, ST_IDLE);
    clk_step();
    check("rrun_tick2",   bus.tick, 0);

    // random traffic against the reference model via the scoreboard
    for (int i = 0; i < 600; i++) begin
      reset = (i == 0) || ($urandom_range(0, 79) == 0);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5));
      model_edge();
      exp_q.push_back({m_tick, m_run, m_presc, m_ticks});
      clk_step();
      e = exp_q.pop_front();
      check("rand_vec", {bus.tick, bus.running, bus.phase, bus.ticks}, e);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
